// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU operand issuer.
// Beat encodings, multiply commands, FSM states, response flag indices.
package alu_pkg;

  localparam logic [1:0] INP_NONE = 2'b00;
  localparam logic [1:0] INP_A    = 2'b01;
  localparam logic [1:0] INP_B    = 2'b10;
  localparam logic [1:0] INP_AB   = 2'b11;

  localparam logic [3:0] CMD_MUL_INC = 4'd9;
  localparam logic [3:0] CMD_MUL_SHL = 4'd10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_BEAT_A,
    S_GAP,
    S_BEAT_B,
    S_WAIT_RES,
    S_RESP
  } issuer_state_e;

  // resp_flags = {ERR,OFLOW,COUT,G,L,E}
  localparam int FLG_E     = 0;
  localparam int FLG_L     = 1;
  localparam int FLG_G     = 2;
  localparam int FLG_COUT  = 3;
  localparam int FLG_OFLOW = 4;
  localparam int FLG_ERR   = 5;
  localparam int FLG_W     = 6;

endpackage

// File: rtl/alu_beat_timer.sv
// Loadable down-counter timing the inter-beat gap and result latency.
// Ports: clk, rst, load, load_val in; done high while count is 1 or less.
module alu_beat_timer #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // A loaded value of N keeps the owning state for exactly N cycles;
  // zero or one both end after a single cycle.
  assign done = (count_q <= W'(1));

endmodule

// File: rtl/alu_op_issuer.sv
// Drives ALU operand beats from a request handshake, returns RES/flags.
// Ports: req_* in, OPA/OPB/CMD/MODE/CIN/CE/INP_VALID to ALU, resp_* out.
module alu_op_issuer
  import alu_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int CMD_W      = 4,
  parameter int RES_LAT    = 1,
  parameter int MUL_LAT    = 2,
  parameter int WAIT_LIMIT = 16,
  parameter int GAP_W      = 5
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [WIDTH-1:0]   req_opa,
  input  logic [WIDTH-1:0]   req_opb,
  input  logic [CMD_W-1:0]   req_cmd,
  input  logic               req_mode,
  input  logic               req_cin,
  input  logic               req_split,
  input  logic [GAP_W-1:0]   req_gap,
  output logic [WIDTH-1:0]   OPA,
  output logic [WIDTH-1:0]   OPB,
  output logic [CMD_W-1:0]   CMD,
  output logic               MODE,
  output logic               CIN,
  output logic               CE,
  output logic [1:0]         INP_VALID,
  input  logic [2*WIDTH-1:0] RES,
  input  logic               G,
  input  logic               L,
  input  logic               E,
  input  logic               ERR,
  input  logic               COUT,
  input  logic               OFLOW,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [2*WIDTH-1:0] resp_res,
  output logic [FLG_W-1:0]   resp_flags,
  output logic               resp_late
);

  localparam logic [GAP_W:0]   WAIT_LIM = (GAP_W+1)'(WAIT_LIMIT);
  localparam logic [GAP_W-1:0] LAT_RES  = GAP_W'(RES_LAT);
  localparam logic [GAP_W-1:0] LAT_MUL  = GAP_W'(MUL_LAT);

  issuer_state_e state_q, state_d;

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [CMD_W-1:0] cmd_q, cmd_d;
  logic             mode_q, mode_d;
  logic             cin_q, cin_d;
  logic             split_q, split_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             late_q, late_d;

  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [CMD_W-1:0] cmd_o_q, cmd_o_d;
  logic             mode_o_q, mode_o_d;
  logic             cin_o_q, cin_o_d;
  logic             ce_q, ce_d;
  logic [1:0]       iv_q, iv_d;

  logic               rv_q, rv_d;
  logic [2*WIDTH-1:0] rres_q, rres_d;
  logic [FLG_W-1:0]   rfl_q, rfl_d;
  logic               rlate_q, rlate_d;

  logic             tmr_load;
  logic [GAP_W-1:0] tmr_val;
  logic             tmr_done;

  // Beat fields come straight from the request on the accept cycle,
  // because the latched copies only settle at that same edge.
  logic             from_req;
  logic [WIDTH-1:0] src_a, src_b;
  logic [CMD_W-1:0] src_cmd;
  logic             src_mode, src_cin, src_split;
  logic             is_mul;
  logic [GAP_W:0]   gap_p1;

  assign from_req  = (state_q == S_IDLE);
  assign src_a     = from_req ? req_opa   : a_q;
  assign src_b     = from_req ? req_opb   : b_q;
  assign src_cmd   = from_req ? req_cmd   : cmd_q;
  assign src_mode  = from_req ? req_mode  : mode_q;
  assign src_cin   = from_req ? req_cin   : cin_q;
  assign src_split = from_req ? req_split : split_q;

  assign is_mul = mode_q &&
    ((cmd_q == CMD_W'(CMD_MUL_INC)) ||
     (cmd_q == CMD_W'(CMD_MUL_SHL)));

  assign gap_p1 = {1'b0, req_gap} + (GAP_W+1)'(1);

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    cmd_d    = cmd_q;
    mode_d   = mode_q;
    cin_d    = cin_q;
    split_d  = split_q;
    gap_d    = gap_q;
    late_d   = late_q;
    rv_d     = rv_q;
    rres_d   = rres_q;
    rfl_d    = rfl_q;
    rlate_d  = rlate_q;
    tmr_load = 1'b0;
    tmr_val  = gap_q;

    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          a_d     = req_opa;
          b_d     = req_opb;
          cmd_d   = req_cmd;
          mode_d  = req_mode;
          cin_d   = req_cin;
          split_d = req_split;
          gap_d   = req_gap;
          late_d  = req_split && (gap_p1 >= WAIT_LIM);
          state_d = req_split ? S_BEAT_A : S_BEAT_B;
        end
      end
      S_BEAT_A: begin
        tmr_load = 1'b1;
        tmr_val  = gap_q;
        state_d  = (gap_q == '0) ? S_BEAT_B : S_GAP;
      end
      S_GAP: begin
        if (tmr_done) state_d = S_BEAT_B;
      end
      S_BEAT_B: begin
        tmr_load = 1'b1;
        tmr_val  = is_mul ? LAT_MUL : LAT_RES;
        state_d  = S_WAIT_RES;
      end
      S_WAIT_RES: begin
        if (tmr_done) begin
          rres_d           = RES;
          rfl_d[FLG_ERR]   = ERR;
          rfl_d[FLG_OFLOW] = OFLOW;
          rfl_d[FLG_COUT]  = COUT;
          rfl_d[FLG_G]     = G;
          rfl_d[FLG_L]     = L;
          rfl_d[FLG_E]     = E;
          rlate_d          = late_q;
          rv_d             = 1'b1;
          state_d          = S_RESP;
        end
      end
      S_RESP: begin
        if (resp_ready) begin
          rv_d    = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ALU-side outputs are registered off the next state so they line
  // up with the state they belong to; unused fields hold their value.
  always_comb begin
    opa_d    = opa_q;
    opb_d    = opb_q;
    cmd_o_d  = cmd_o_q;
    mode_o_d = mode_o_q;
    cin_o_d  = cin_o_q;
    ce_d     = 1'b0;
    iv_d     = INP_NONE;

    unique case (state_d)
      S_BEAT_A: begin
        ce_d     = 1'b1;
        iv_d     = INP_A;
        opa_d    = src_a;
        cmd_o_d  = src_cmd;
        mode_o_d = src_mode;
        cin_o_d  = src_cin;
      end
      S_GAP, S_WAIT_RES: begin
        ce_d = 1'b1;
      end
      S_BEAT_B: begin
        ce_d     = 1'b1;
        iv_d     = src_split ? INP_B : INP_AB;
        opb_d    = src_b;
        cmd_o_d  = src_cmd;
        mode_o_d = src_mode;
        cin_o_d  = src_cin;
        if (!src_split) opa_d = src_a;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      cmd_q    <= '0;
      mode_q   <= 1'b0;
      cin_q    <= 1'b0;
      split_q  <= 1'b0;
      gap_q    <= '0;
      late_q   <= 1'b0;
      opa_q    <= '0;
      opb_q    <= '0;
      cmd_o_q  <= '0;
      mode_o_q <= 1'b0;
      cin_o_q  <= 1'b0;
      ce_q     <= 1'b0;
      iv_q     <= INP_NONE;
      rv_q     <= 1'b0;
      rres_q   <= '0;
      rfl_q    <= '0;
      rlate_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      cmd_q    <= cmd_d;
      mode_q   <= mode_d;
      cin_q    <= cin_d;
      split_q  <= split_d;
      gap_q    <= gap_d;
      late_q   <= late_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      cmd_o_q  <= cmd_o_d;
      mode_o_q <= mode_o_d;
      cin_o_q  <= cin_o_d;
      ce_q     <= ce_d;
      iv_q     <= iv_d;
      rv_q     <= rv_d;
      rres_q   <= rres_d;
      rfl_q    <= rfl_d;
      rlate_q  <= rlate_d;
    end
  end

  alu_beat_timer #(
    .W(GAP_W)
  ) u_timer (
    .clk      (CLK),
    .rst      (RST),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  // Held low through reset so nothing is offered while RST is high.
  assign req_ready  = (state_q == S_IDLE) && !RST;
  assign OPA        = opa_q;
  assign OPB        = opb_q;
  assign CMD        = cmd_o_q;
  assign MODE       = mode_o_q;
  assign CIN        = cin_o_q;
  assign CE         = ce_q;
  assign INP_VALID  = iv_q;
  assign resp_valid = rv_q;
  assign resp_res   = rres_q;
  assign resp_flags = rfl_q;
  assign resp_late  = rlate_q;

endmodule
